// File: rtl/johnson_decoder.sv
// Purpose: decode a sampled Johnson code to a binary index, check its sequence, track sync state and errors.
// Latency: one cycle; outputs reflect the sample taken on the clk edge where sample_en=1.
// Backpressure: none; sample_en gates sampling, and q_in is ignored on cycles where it is 0.
module johnson_decoder #(
  parameter int N    = 4,
  parameter int IDXW = 3,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sample_en,
  input  logic [N-1:0]    q_in,
  output logic [IDXW-1:0] idx,
  output logic            idx_valid,
  output logic            illegal,
  output logic            step_err,
  output logic            locked,
  output logic [ERRW-1:0] err_count
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(2*N-1);
  localparam logic [ERRW-1:0] ERR_MAX  = '1;

  logic [1:0]      state, nxt_state;
  logic [IDXW-1:0] prev, nxt_prev, nxt_idx, succ, k;
  logic            legal, vld_n, ill_n, serr_n;

  // Code k has ones in the low k bits for k<N, and ones from bit k-N upward for k>=N.
  function automatic logic [N-1:0] code_of(input int j);
    logic [N-1:0] c;
    for (int i = 0; i < N; i++) begin
      if (j < N) c[i] = (i < j);
      else       c[i] = (i >= j - N);
    end
    return c;
  endfunction

  // Combinational decode: match the input against each of the 2N legal codes.
  always_comb begin
    legal = 1'b0;
    k     = '0;
    for (int j = 0; j < 2*N; j++) begin
      if (q_in == code_of(j)) begin
        legal = 1'b1;
        k     = IDXW'(j);
      end
    end
  end

  assign succ = (prev == LAST_IDX) ? '0 : prev + IDXW'(1);

  // Next-state logic for the sync FSM, index and pulses; only a sampled cycle may change anything.
  always_comb begin
    nxt_state = state;
    nxt_prev  = prev;
    nxt_idx   = idx;
    vld_n     = 1'b0;
    ill_n     = 1'b0;
    serr_n    = 1'b0;
    if (sample_en) begin
      if (legal) begin
        nxt_idx  = k;
        vld_n    = 1'b1;
        nxt_prev = k;
        case (state)
          ST_HUNT:  nxt_state = ST_ARMED;
          ST_ARMED: if (k == succ) nxt_state = ST_LOCKED;
          ST_LOCKED: begin
            // A repeat is a stalled counter, not a violation.
            if (k != succ && k != prev) begin
              serr_n    = 1'b1;
              nxt_state = ST_ARMED;
            end
          end
          default:  nxt_state = ST_HUNT;
        endcase
      end else begin
        ill_n     = 1'b1;
        nxt_state = ST_HUNT;
      end
    end
  end

  // Register state, decoded index, status pulses and the saturating error count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_HUNT;
      prev      <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      illegal   <= 1'b0;
      step_err  <= 1'b0;
      locked    <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= nxt_state;
      prev      <= nxt_prev;
      idx       <= nxt_idx;
      idx_valid <= vld_n;
      illegal   <= ill_n;
      step_err  <= serr_n;
      locked    <= (nxt_state == ST_LOCKED);
      // illegal and step_err are mutually exclusive, so at most one increment per cycle.
      if ((ill_n || serr_n) && err_count != ERR_MAX)
        err_count <= err_count + ERRW'(1);
    end
  end

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed table-driven bench for johnson_decoder (N=4), plus a narrow-counter instance for saturation and async reset.
// Codes in the table are written q0q1q2q3 and bit-reversed onto q_in.
// Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
module tb_johnson_decoder;

  logic       clk = 1'b0;
  logic       reset, reset2;
  logic       sample_en, sample_en2;
  logic [3:0] q_in, q_in2;
  logic [2:0] idx, idx2;
  logic       idx_valid, illegal, step_err, locked;
  logic       idx_valid2, illegal2, step_err2, locked2;
  logic [7:0] err_count;
  logic [1:0] err_count2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  johnson_decoder #(.N(4), .IDXW(3), .ERRW(8)) dut (
    .clk(clk), .reset(reset), .sample_en(sample_en), .q_in(q_in),
    .idx(idx), .idx_valid(idx_valid), .illegal(illegal), .step_err(step_err),
    .locked(locked), .err_count(err_count)
  );

  johnson_decoder #(.N(4), .IDXW(3), .ERRW(2)) dut2 (
    .clk(clk), .reset(reset2), .sample_en(sample_en2), .q_in(q_in2),
    .idx(idx2), .idx_valid(idx_valid2), .illegal(illegal2), .step_err(step_err2),
    .locked(locked2), .err_count(err_count2)
  );

  typedef struct {
    logic       en;
    logic [3:0] q;     // written q0q1q2q3
    logic [2:0] idx;
    logic       vld;
    logic       ill;
    logic       serr;
    logic       lck;
    logic [7:0] errc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [3:0] rev(input logic [3:0] s);
    return {s[0], s[1], s[2], s[3]};
  endfunction

  function automatic vec_t mk(input logic en, input logic [3:0] q, input logic [2:0] i,
                              input logic v, input logic il, input logic se,
                              input logic l, input logic [7:0] e);
    vec_t r;
    r.en = en; r.q = q; r.idx = i; r.vld = v; r.ill = il; r.serr = se; r.lck = l; r.errc = e;
    return r;
  endfunction

  task automatic check_main(input string name, input vec_t e);
    total++;
    if (idx === e.idx && idx_valid === e.vld && illegal === e.ill &&
        step_err === e.serr && locked === e.lck && err_count === e.errc)
      passed++;
    else
      $display("FAIL %s: got idx=%0d vld=%b ill=%b serr=%b lck=%b err=%0d, want idx=%0d vld=%b ill=%b serr=%b lck=%b err=%0d",
               name, idx, idx_valid, illegal, step_err, locked, err_count,
               e.idx, e.vld, e.ill, e.serr, e.lck, e.errc);
  endtask

  task automatic check2(input string name, input logic [9:0] got, input logic [9:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  initial begin
    //                 en  q0q1q2q3  idx  vld ill serr lck err
    // legal sequence from reset; lock after the 2nd sample
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1000, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'b1100, 2, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'b1110, 3, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'b1111, 4, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'b0111, 5, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'b0011, 6, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'b0001, 7, 1, 0, 0, 1, 0));
    // repeat 0001, then wrap to 0000
    tbl.push_back(mk(1, 4'b0001, 7, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'b1000, 1, 1, 0, 0, 1, 0));
    tbl.push_back(mk(1, 4'b1100, 2, 1, 0, 0, 1, 0));
    // skip 2 -> 4: step error, drop to ARMED, then successor relocks
    tbl.push_back(mk(1, 4'b1111, 4, 1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 4'b0111, 5, 1, 0, 0, 1, 1));
    // illegal while locked: idx holds, HUNT
    tbl.push_back(mk(1, 4'b1010, 5, 0, 1, 0, 0, 2));
    tbl.push_back(mk(1, 4'b1000, 1, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 4'b1100, 2, 1, 0, 0, 1, 2));
    // sampling disabled while q_in wanders
    tbl.push_back(mk(0, 4'b1010, 2, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 4'b0110, 2, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 4'b1111, 2, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 4'b0000, 2, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 4'b0101, 2, 0, 0, 0, 1, 2));
    // same code twice: stall, no error
    tbl.push_back(mk(1, 4'b1100, 2, 1, 0, 0, 1, 2));
    tbl.push_back(mk(1, 4'b1100, 2, 1, 0, 0, 1, 2));
    // illegal in LOCKED, illegal in HUNT, then non-successor in ARMED is not a step error
    tbl.push_back(mk(1, 4'b0100, 2, 0, 1, 0, 0, 3));
    tbl.push_back(mk(1, 4'b0110, 2, 0, 1, 0, 0, 4));
    tbl.push_back(mk(1, 4'b0011, 6, 1, 0, 0, 0, 4));
    tbl.push_back(mk(1, 4'b1000, 1, 1, 0, 0, 0, 4));
    tbl.push_back(mk(1, 4'b1100, 2, 1, 0, 0, 1, 4));

    reset = 1'b1; reset2 = 1'b1;
    sample_en = 1'b0; sample_en2 = 1'b0;
    q_in = 4'b0000; q_in2 = 4'b0000;
    repeat (2) @(negedge clk);
    check_main("reset", mk(0, 4'b0000, 0, 0, 0, 0, 0, 0));
    reset = 1'b0; reset2 = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      sample_en = tbl[i].en;
      q_in      = rev(tbl[i].q);
      @(posedge clk);
      #1;
      check_main($sformatf("vec%0d", i), tbl[i]);
    end
    @(negedge clk);
    sample_en = 1'b0;

    // Narrow counter: five illegal samples saturate at 3.
    for (int n = 0; n < 5; n++) begin
      logic [1:0] want;
      want = (n < 3) ? 2'(n + 1) : 2'd3;
      @(negedge clk);
      sample_en2 = 1'b1;
      q_in2      = rev(4'b1010);
      @(posedge clk);
      #1;
      check2($sformatf("sat%0d", n), {8'd0, err_count2}, {8'd0, want});
    end
    // Lock, then reset between edges must clear outputs at once.
    @(negedge clk); q_in2 = rev(4'b0000);
    @(negedge clk); q_in2 = rev(4'b1000);
    @(posedge clk);
    #1;
    check2("lock2", {idx2, idx_valid2, illegal2, step_err2, locked2, 1'b0, err_count2},
                    {3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3});
    #1;
    reset2 = 1'b1;
    #1;
    check2("async_rst", {idx2, idx_valid2, illegal2, step_err2, locked2, 1'b0, err_count2}, 10'd0);
    @(negedge clk);
    sample_en2 = 1'b0;
    reset2 = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
